// File: rtl/elevator_ctrl.sv
// Elevator car controller: latches floor calls, picks direction by SCAN and
// sequences travel and door dwell through a restartable seconds timer.
module elevator_ctrl #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2,
    parameter int TRAVEL_SEC = 2,
    parameter int DOOR_SEC   = 3
) (
    input  logic                  clk,
    input  logic                  reseta,
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [3:0]            timeout,
    input  logic                  done_reset_clock,
    output logic                  clock_reset,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOVE_ARM = 3'd1,
        MOVE     = 3'd2,
        DOOR_ARM = 3'd3,
        DOOR     = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [FLOOR_W-1:0]      w_floor_nxt;
    logic [FLOOR_W-1:0]      w_floor_step;
    logic                    w_dir_nxt;
    logic [NUM_FLOORS-1:0]   w_req_eff;
    logic [NUM_FLOORS-1:0]   w_clr;
    logic [NUM_FLOORS-1:0]   w_pend_nxt;

    function automatic logic calls_beyond(input logic [NUM_FLOORS-1:0] pend,
                                          input logic [FLOOR_W-1:0]    fl,
                                          input logic                  up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((up && (i > int'(fl))) || (!up && (i < int'(fl))))
                hit = hit | pend[i];
        end
        return hit;
    endfunction

    // Saturating step keeps the car inside the shaft even if direction logic misbehaves.
    always_comb begin
        w_floor_step = floor;
        if (dir_up) begin
            if (floor != FLOOR_W'(NUM_FLOORS - 1))
                w_floor_step = floor + FLOOR_W'(1);
        end else begin
            if (floor != '0)
                w_floor_step = floor - FLOOR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_floor_nxt = floor;
        w_dir_nxt   = dir_up;
        w_clr       = '0;
        w_req_eff   = req;
        if (r_state == DOOR)
            w_req_eff[floor] = 1'b0;

        case (r_state)
            IDLE: begin
                if (pending[floor]) begin
                    w_clr[floor] = 1'b1;
                    w_state_nxt  = DOOR_ARM;
                end else if (|pending) begin
                    w_dir_nxt   = calls_beyond(pending, floor, dir_up) ? dir_up : !dir_up;
                    w_state_nxt = MOVE_ARM;
                end
            end
            MOVE_ARM: begin
                if (done_reset_clock)
                    w_state_nxt = MOVE;
            end
            MOVE: begin
                if (timeout == 4'(TRAVEL_SEC)) begin
                    w_floor_nxt = w_floor_step;
                    if (pending[w_floor_step]) begin
                        w_clr[w_floor_step] = 1'b1;
                        w_state_nxt         = DOOR_ARM;
                    end else if (calls_beyond(pending, w_floor_step, dir_up)) begin
                        w_state_nxt = MOVE_ARM;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            DOOR_ARM: begin
                if (done_reset_clock)
                    w_state_nxt = DOOR;
            end
            DOOR: begin
                // A call at the open door extends the dwell instead of latching.
                if (req[floor])
                    w_state_nxt = DOOR_ARM;
                else if (timeout == 4'(DOOR_SEC))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        w_pend_nxt = (pending & ~w_clr) | w_req_eff;
    end

    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            r_state     <= IDLE;
            floor       <= '0;
            dir_up      <= 1'b1;
            pending     <= '0;
            clock_reset <= 1'b0;
            moving      <= 1'b0;
            door_open   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            floor       <= w_floor_nxt;
            dir_up      <= w_dir_nxt;
            pending     <= w_pend_nxt;
            clock_reset <= (w_state_nxt == MOVE_ARM) || (w_state_nxt == DOOR_ARM);
            moving      <= (w_state_nxt == MOVE_ARM) || (w_state_nxt == MOVE);
            door_open   <= (w_state_nxt == DOOR_ARM) || (w_state_nxt == DOOR);
        end
    end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car controller sitting directly downstream of the seconds timer (clock_sim).
- Latches floor-call buttons and decides travel direction with a SCAN policy.
- Times floor-to-floor travel and door dwell by restarting the timer and comparing its 4-bit seconds count.
- Drives floor, direction, motion and door indications to the display/top level.

Parameters:
- NUM_FLOORS, 4, number of floors, 2..8.
- FLOOR_W, 2, floor index width, clog2(NUM_FLOORS).
- TRAVEL_SEC, 2, seconds per one-floor move, 1..15.
- DOOR_SEC, 3, seconds door stays open, 1..15.

Ports:
- clk  in  1  system clock, same clock as the timer.
- reseta  in  1  asynchronous, active-low reset.
- req  in  NUM_FLOORS  call buttons, one bit per floor, any length >=1 cycle.
- timeout  in  4  elapsed seconds from timer, wraps 15->0.
- done_reset_clock  in  1  timer acknowledge: high the cycle after the timer sampled its restart.
- clock_reset  out  1  active-high restart request to timer (drives its reseta).
- floor  out  FLOOR_W  current car floor.
- dir_up  out  1  1 = up, 0 = down (last/current direction).
- moving  out  1  high in MOVE_ARM/MOVE.
- door_open  out  1  high in DOOR_ARM/DOOR.
- pending  out  NUM_FLOORS  latched outstanding calls.

Behaviour:
- Reset (reseta=0, async): state=IDLE, floor=0, dir_up=1, pending=0, clock_reset=0, moving=0, door_open=0.
- Call latching:
  - pending |= req every cycle; bits are sticky.
  - A bit clears only on arrival/service at that floor (see below).
  - Clear and set of the same bit in the same cycle -> set wins only if the car is not in DOOR at that floor.
- States are IDLE, MOVE_ARM, MOVE, DOOR_ARM, DOOR. All outputs are registered.
- IDLE:
  - pending==0: stay.
  - pending[floor]: clear it -> DOOR_ARM.
  - Otherwise pick direction:
    - Keep dir_up if any call lies beyond the car in that direction.
    - Else reverse.
    - Then -> MOVE_ARM.
- MOVE_ARM / DOOR_ARM (timer restart handshake):
  - clock_reset=1 until done_reset_clock=1 is sampled.
  - On that cycle: clock_reset=0 and go to MOVE / DOOR respectively.
  - No timeout limit on waiting.
- MOVE:
  - When timeout==TRAVEL_SEC: floor +/-1 by dir_up.
  - If pending[new floor]: clear it -> DOOR_ARM.
  - Else if calls remain beyond new floor in dir_up -> MOVE_ARM.
  - Else -> IDLE.
- DOOR:
  - New req at current floor: pending bit is not set, and the dwell restarts via DOOR_ARM.
  - When timeout==DOOR_SEC -> IDLE.
- Bounds:
  - floor never decrements below 0 nor increments above NUM_FLOORS-1.
  - Direction selection guarantees this; an out-of-range step is a design error, flagged by a bench assertion.
- Comparisons use ==; thresholds above 15 are illegal (4-bit wrap).
- reseta asserted mid-move or mid-dwell: immediate return to reset values; the timer is not restarted until the next ARM state.
- Latency:
  - Call at idle, non-current floor -> clock_reset rises 1 cycle after req is registered.
  - Call at current floor -> door_open 1 cycle after the pending bit.

Test Plan:
1. Reset, then req=4'b0100 pulse (timer stub: 1 second = 10 cycles)
   -> moving=1, dir_up=1, floor 0->1->2 at each timeout==2; then door_open=1 for 3 s; pending[2] cleared; then IDLE.
2. Car at floor 2 idle, req=4'b0100
   -> no movement, door_open=1 next cycle, closes after 3 s.
3. Car at 1 moving up to 3, req[0] and req[2] asserted
   -> stops at 2 (door), continues to 3, then reverses (dir_up=0) to 0.
4. In DOOR at floor 1, req[1] pulsed at timeout==2
   -> dwell restarts; door_open stays high 3 more seconds; pending[1] stays 0.
5. Hold done_reset_clock=0 for 50 cycles in MOVE_ARM
   -> clock_reset stays 1, floor unchanged; on ack clock_reset drops same cycle and MOVE entered.
6. Assert reseta=0 mid-MOVE at floor 2
   -> all outputs return to reset values asynchronously; pending=0.
